wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter placed directly upstream of the address-decoding interconnect.
//  Merges NM master ports (e.g. CPU, housekeeping SPI, debug) into the interconnect's single master port.
//  Bus-watchdog: a stalled access is completed with an error instead of hanging the system.
// PARAMETERS
//  NM        2              number of masters (2..8)
//  AW        32             address width
//  DW        32             data width (multiple of 8)
//  TIMEOUT   255            cycles of stb-without-ack before error termination (>=2)
//  ERR_DATA  32'hDEAD_BEEF  read data returned on timeout
// PORTS
//  wb_clk_i     in   1        clock; all state on rising edge
//  wb_rst_ni    in   1        synchronous, active-low reset
//  m_cyc_i      in   NM       per-master cycle request
//  m_stb_i      in   NM       per-master strobe
//  m_we_i       in   NM       per-master write enable
//  m_sel_i      in   NM*DW/8  per-master byte selects, master k at [k*DW/8 +: DW/8]
//  m_adr_i      in   NM*AW    per-master address, master k at [k*AW +: AW]
//  m_dat_i      in   NM*DW    per-master write data, master k at [k*DW +: DW]
//  m_dat_o      out  DW       read data, broadcast to all masters
//  m_ack_o      out  NM       ack, only to granted master
//  m_err_o      out  NM       timeout error, only to granted master
//  s_cyc_o      out  1        to interconnect
//  s_stb_o      out  1        to interconnect strobe input
//  s_we_o       out  1        to slaves
//  s_sel_o      out  DW/8     to slaves
//  s_adr_o      out  AW       to interconnect address input
//  s_dat_o      out  DW       write data to slaves
//  s_dat_i      in   DW       interconnect read-data output
//  s_ack_i      in   1        interconnect ack output
//  gnt_o        out  NM       one-hot current grant (debug/status)
// BEHAVIOUR
//  - Reset (wb_rst_ni=0 at a clock edge): state=IDLE, gnt_o=0, last-granted pointer=NM-1
//    (master 0 has top priority first), timeout counter=0.
//  - With no grant, all s_* outputs, m_ack_o, m_err_o are 0; m_dat_o = s_dat_i.
//  - FSM IDLE: if any m_cyc_i, register one-hot grant to the first requester searching
//    last+1, last+2, ... (mod NM); go BUSY. Arbitration latency: exactly 1 cycle.
//  - FSM BUSY: s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o combinationally
//    mux the granted master's inputs. m_ack_o[g]=s_ack_i; m_dat_o=s_dat_i.
//  - Grant is held across multiple stb/ack beats while m_cyc_i[g]=1 (no preemption).
//  - m_cyc_i[g] falling: the same cycle sees s_cyc_o=0; next edge -> IDLE, gnt_o=0,
//    last=g. No back-to-back re-grant without one IDLE cycle.
//  - Watchdog: counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0; clears
//    on s_ack_i, on stb low, and on leaving BUSY.
//    When the counter equals TIMEOUT-1 and s_ack_i=0: m_err_o[g]=1 for that one cycle,
//    m_dat_o=ERR_DATA, s_stb_o forced to 0; counter clears.
//    m_ack_o[g] stays 0 on error.
//  - A late s_ack_i in the cycle after an error is ignored (not forwarded).
//  - Simultaneous ack and terminal count: ack wins, no error.
//  - Requests from non-granted masters are stalled (no ack/err) until they win arbitration.
//  - Reset mid-transfer: all outputs drop to reset values at that edge. The in-flight
//    access is abandoned.
//  - m_ack_o and m_err_o are never both 1, and are at most one-hot across masters.
// TESTING
//  1 Reset, then master0 read 0x2100_0000, slave ack at cycle 3 -> gnt_o=01 one cycle
//    after cyc; m_ack_o=01; m_dat_o=s_dat_i.
//  2 Both masters raise cyc in the same cycle from reset -> master0 granted first.
//    After master0 drops cyc: one IDLE cycle, then master1 granted.
//  3 Master1 holds cyc over 4 stb/ack beats while master0 requests -> gnt_o stays 10
//    until m_cyc_i[1]=0.
//  4 Slave never acks, TIMEOUT=255 -> m_err_o[g]=1 on the 255th stb cycle,
//    m_dat_o=32'hDEAD_BEEF; s_stb_o=0 that cycle.
//  5 Ack arrives on the same cycle as terminal count -> m_ack_o=1, m_err_o=0.
//  6 Pull wb_rst_ni low while BUSY with write to 0x2000_0000 -> next edge: gnt_o=0,
//    s_cyc_o=0, s_stb_o=0; next request goes to master0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter merging NM masters onto one port, with a stall watchdog
//  wb_clk_i/wb_rst_ni : clock, synchronous active-low reset
//  m_*_i / m_*_o      : packed per-master request buses (master k at slice k), read data broadcast
//  s_*_o / s_*_i      : single master port toward the interconnect
//  gnt_o              : one-hot current grant
module wb_arbiter #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  output logic [NM-1:0]        gnt_o
);
  localparam int SW = DW / 8;
  localparam int LW = NM > 1 ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nx;
  logic [NM-1:0] r_gnt, w_gnt_nx, w_pick;
  logic [LW-1:0] r_last, w_last_nx, w_gidx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic r_err_d, w_err_d_nx;
  logic w_cyc, w_stb, w_we, w_to;
  logic [SW-1:0] w_sel;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_dat;
  // walk from the lowest priority upward so the highest-priority requester is written last
  always_comb begin
    w_pick = '0;
    for (int i = NM; i > 0; i--)
      if (m_cyc_i[(int'(r_last) + i) % NM]) begin
        w_pick = '0;
        w_pick[(int'(r_last) + i) % NM] = 1'b1;
      end
  end
  always_comb begin
    w_gidx = '0;
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we = 1'b0;
    w_sel = '0;
    w_adr = '0;
    w_dat = '0;
    for (int k = 0; k < NM; k++)
      if (r_gnt[k]) begin
        w_gidx = LW'(k);
        w_cyc = m_cyc_i[k];
        w_stb = m_stb_i[k];
        w_we = m_we_i[k];
        w_sel = m_sel_i[k*SW +: SW];
        w_adr = m_adr_i[k*AW +: AW];
        w_dat = m_dat_i[k*DW +: DW];
      end
  end
  assign w_to = w_cyc & w_stb & ~s_ack_i & (r_cnt == CW'(TIMEOUT - 1));
  assign s_cyc_o = w_cyc;
  assign s_stb_o = w_cyc & w_stb & ~w_to;
  assign s_we_o = w_we;
  assign s_sel_o = w_sel;
  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  // an ack straggling in right after a timeout belongs to the abandoned access
  assign m_ack_o = r_gnt & {NM{w_cyc & s_ack_i & ~r_err_d}};
  assign m_err_o = r_gnt & {NM{w_to}};
  assign m_dat_o = w_to ? ERR_DATA : s_dat_i;
  assign gnt_o = r_gnt;
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx = r_gnt;
    w_last_nx = r_last;
    w_cnt_nx = '0;
    w_err_d_nx = 1'b0;
    if (r_state == IDLE) begin
      if (|m_cyc_i) begin
        w_state_nx = BUSY;
        w_gnt_nx = w_pick;
      end
    end else if (!w_cyc) begin
      w_state_nx = IDLE;
      w_gnt_nx = '0;
      w_last_nx = w_gidx;
    end else begin
      w_cnt_nx = (w_stb && !s_ack_i && !w_to) ? r_cnt + 1'b1 : '0;
      w_err_d_nx = w_to;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_last <= LW'(NM - 1);
      r_cnt <= '0;
      r_err_d <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt <= w_gnt_nx;
      r_last <= w_last_nx;
      r_cnt <= w_cnt_nx;
      r_err_d <= w_err_d_nx;
    end
  end
endmodule
